// File: rtl/shared_ram_arbiter.sv
// rtl/shared_ram_arbiter.sv - shares one 32-bit single-port RAM between the CPU word port and byte-wide DMA ports
module shared_ram_arbiter #(
   parameter int AW           = 10,
   parameter int NUM_DMA      = 2,
   parameter int MAX_CPU_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_valid,
   input  logic [AW-1:0]         cpu_addr,
   input  logic [31:0]           cpu_wdata,
   input  logic [3:0]            cpu_wstrb,
   output logic                  cpu_ready,
   output logic [31:0]           cpu_rdata,
   input  logic [NUM_DMA-1:0]    dma_req,
   input  logic [NUM_DMA-1:0]    dma_we,
   input  logic [NUM_DMA*AW-1:0] dma_addr,
   input  logic [NUM_DMA*8-1:0]  dma_wdata,
   output logic [NUM_DMA-1:0]    dma_gnt,
   output logic [NUM_DMA-1:0]    dma_rvalid,
   output logic [7:0]            dma_rdata,
   output logic                  ram_ce,
   output logic [AW-3:0]         ram_addr,
   output logic [3:0]            ram_we,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);
   localparam int PW = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
   localparam int SW = (MAX_CPU_WAIT > 0) ? $clog2(MAX_CPU_WAIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_CPU_WAIT);
   localparam logic [PW-1:0] RR_RESET   = PW'(NUM_DMA - 1);

   logic [PW-1:0]      rr_ptr;
   logic [SW-1:0]      starve_cnt;
   logic               cpu_ready_q;
   logic [NUM_DMA-1:0] rvalid_q;
   logic [1:0]         lane_q;

   logic               cpu_elig;
   logic               cpu_gnt;
   logic               dma_any;
   logic [PW-1:0]      dma_idx;
   logic [AW-1:0]      sel_addr;
   logic [7:0]         sel_byte;
   logic               sel_we;
   logic               unused_ok;

   assign cpu_elig = cpu_valid & ~cpu_ready_q;

   // Round-robin scan starts just after the last granted port and wraps.
   always_comb begin
      int p;
      p       = 0;
      dma_any = 1'b0;
      dma_idx = '0;
      for (int k = 1; k <= NUM_DMA; k++) begin
         p = (int'(rr_ptr) + k) % NUM_DMA;
         if (!dma_any && dma_req[p]) begin
            dma_any = 1'b1;
            dma_idx = PW'(p);
         end
      end
   end

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = '0;
      if (!rst) begin
         if (cpu_elig && starve_cnt == STARVE_MAX) cpu_gnt = 1'b1;
         else if (dma_any)                         dma_gnt[dma_idx] = 1'b1;
         else if (cpu_elig)                        cpu_gnt = 1'b1;
      end
   end

   assign sel_addr = dma_addr[int'(dma_idx)*AW +: AW];
   assign sel_byte = dma_wdata[int'(dma_idx)*8 +: 8];
   assign sel_we   = dma_we[dma_idx];

   always_comb begin
      ram_ce    = 1'b0;
      ram_addr  = '0;
      ram_we    = 4'b0000;
      ram_wdata = '0;
      if (cpu_gnt) begin
         ram_ce    = 1'b1;
         ram_addr  = cpu_addr[AW-1:2];
         ram_we    = cpu_wstrb;
         ram_wdata = cpu_wdata;
      end else if (|dma_gnt) begin
         ram_ce    = 1'b1;
         ram_addr  = sel_addr[AW-1:2];
         ram_wdata = {4{sel_byte}};
         ram_we    = sel_we ? (4'b0001 << sel_addr[1:0]) : 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_ready_q <= 1'b0;
         rvalid_q    <= '0;
         rr_ptr      <= RR_RESET;
         starve_cnt  <= '0;
         lane_q      <= 2'b00;
      end else begin
         cpu_ready_q <= cpu_gnt;
         rvalid_q    <= dma_gnt & {NUM_DMA{~sel_we}};
         if (|dma_gnt) begin
            rr_ptr <= dma_idx;
            lane_q <= sel_addr[1:0];
         end
         if (!cpu_valid || cpu_gnt)                     starve_cnt <= '0;
         else if (cpu_elig && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Responses still in flight when reset is asserted are suppressed.
   assign cpu_ready  = cpu_ready_q & ~rst;
   assign dma_rvalid = rvalid_q & {NUM_DMA{~rst}};
   assign cpu_rdata  = ram_rdata;
   assign dma_rdata  = 8'(ram_rdata >> {lane_q, 3'b000});
   assign unused_ok  = ^cpu_addr[1:0];
endmodule
